// File: rtl/euclid_pkg.sv
// Shared definitions for the Euclid GCD controller and the alu it sequences.
// The ALU command codes must match the alu's own decoding.
package euclid_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] BIGGER  = 3'd0;
    localparam logic [2:0] SMALLER = 3'd1;
    localparam logic [2:0] MODULO  = 3'd2;
    localparam logic [2:0] IDLE    = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAX,
        S_MIN,
        S_MOD,
        S_DONE
    } state_t;

endpackage

// File: rtl/euclid_ctrl.sv
// GCD controller: steps an external combinational alu through max/min and
// repeated modulo commands, one command per clock, to run Euclid's algorithm.
module euclid_ctrl
    import euclid_pkg::*;
#(
    parameter int MAX_ITER = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [2:0]        alu_mode_o,
    output logic [DATA_W-1:0] alu_op_a_o,
    output logic [DATA_W-1:0] alu_op_b_o,
    input  logic [DATA_W-1:0] alu_res_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] gcd_o,
    output logic              err_o
);

    localparam int IW = (MAX_ITER < 1) ? 1 : $clog2(MAX_ITER + 1);

    state_t            state;
    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rb;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [IW-1:0]     iter;
    logic              mod_step;

    // A modulo step happens only while the divisor is nonzero and the budget remains.
    assign mod_step = (y != '0) && (iter != IW'(MAX_ITER));

    always_comb begin
        alu_mode_o = IDLE;
        alu_op_a_o = '0;
        alu_op_b_o = '0;
        case (state)
            S_MAX: begin
                alu_mode_o = BIGGER;
                alu_op_a_o = ra;
                alu_op_b_o = rb;
            end
            S_MIN: begin
                alu_mode_o = SMALLER;
                alu_op_a_o = ra;
                alu_op_b_o = rb;
            end
            S_MOD: begin
                if (mod_step) begin
                    alu_mode_o = MODULO;
                    alu_op_a_o = x;
                    alu_op_b_o = y;
                end
            end
            default: begin
                alu_mode_o = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            ra     <= '0;
            rb     <= '0;
            x      <= '0;
            y      <= '0;
            iter   <= '0;
            gcd_o  <= '0;
            err_o  <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        ra     <= a_i;
                        rb     <= b_i;
                        iter   <= '0;
                        gcd_o  <= '0;
                        err_o  <= 1'b0;
                        busy_o <= 1'b1;
                        state  <= S_MAX;
                    end
                end
                S_MAX: begin
                    x     <= alu_res_i;
                    state <= S_MIN;
                end
                S_MIN: begin
                    y     <= alu_res_i;
                    state <= S_MOD;
                end
                S_MOD: begin
                    if (y == '0) begin
                        gcd_o  <= x;
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end else if (iter == IW'(MAX_ITER)) begin
                        err_o  <= 1'b1;
                        gcd_o  <= '0;
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        x    <= y;
                        y    <= alu_res_i;
                        iter <= iter + 1'b1;
                    end
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_euclid_ctrl.sv
// Self-checking bench for euclid_ctrl: a behavioural alu closes the loop and a
// scoreboard of expected results is popped whenever done_o pulses.
module tb_euclid_ctrl;

    typedef struct {
        logic [15:0] gcd;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start_m, start_l;
    logic [15:0] a_m, b_m, a_l, b_l;
    logic [2:0]  mode_m, mode_l;
    logic [15:0] opa_m, opb_m, opa_l, opb_l;
    logic [15:0] res_m, res_l;
    logic        busy_m, busy_l, done_m, done_l, err_m, err_l;
    logic [15:0] gcd_m, gcd_l;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [2:0] modes_log[$];

    function automatic logic [15:0] alu_model(logic [2:0] m, logic [15:0] a, logic [15:0] b);
        case (m)
            3'd0:    return (a > b) ? a : b;
            3'd1:    return (a < b) ? a : b;
            3'd2:    return (b == 0) ? 16'd0 : a % b;
            default: return 16'd0;
        endcase
    endfunction

    // Binary GCD, deliberately a different algorithm from the one under test.
    function automatic logic [15:0] stein(logic [15:0] a_in, logic [15:0] b_in);
        logic [15:0] a, b, t;
        int sh;
        a = a_in;
        b = b_in;
        sh = 0;
        if (a == 0) return b;
        if (b == 0) return a;
        while (((a | b) & 16'd1) == 0) begin
            a = a >> 1;
            b = b >> 1;
            sh++;
        end
        while ((a & 16'd1) == 0) a = a >> 1;
        do begin
            while ((b & 16'd1) == 0) b = b >> 1;
            if (a > b) begin
                t = a;
                a = b;
                b = t;
            end
            b = b - a;
        end while (b != 0);
        return a << sh;
    endfunction

    assign res_m = alu_model(mode_m, opa_m, opb_m);
    assign res_l = alu_model(mode_l, opa_l, opb_l);

    euclid_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_m), .a_i(a_m), .b_i(b_m),
        .alu_mode_o(mode_m), .alu_op_a_o(opa_m), .alu_op_b_o(opb_m),
        .alu_res_i(res_m), .busy_o(busy_m), .done_o(done_m),
        .gcd_o(gcd_m), .err_o(err_m)
    );

    euclid_ctrl #(.MAX_ITER(2)) dut_lim (
        .clk(clk), .rst(rst), .start_i(start_l), .a_i(a_l), .b_i(b_l),
        .alu_mode_o(mode_l), .alu_op_a_o(opa_l), .alu_op_b_o(opb_l),
        .alu_res_i(res_l), .busy_o(busy_l), .done_o(done_l),
        .gcd_o(gcd_l), .err_o(err_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic expectJob(input logic [15:0] g, input logic e, input int lat);
        exp_t ex;
        ex.gcd = g;
        ex.err = e;
        ex.lat = lat;
        sb.push_back(ex);
    endtask

    // Drives one start pulse; returns just after the accepting edge E0.
    task automatic applyStimulus(input bit sel, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        if (sel) begin
            a_l = a; b_l = b; start_l = 1'b1;
        end else begin
            a_m = a; b_m = b; start_m = 1'b1;
        end
        @(posedge clk);
        #1;
        start_m = 1'b0;
        start_l = 1'b0;
    endtask

    // Called just after E0; n is the index of the edge preceding the sampled cycle.
    task automatic waitDone(input bit sel, input bit rec);
        int   n;
        logic seen;
        exp_t ex;
        n = 0;
        seen = 1'b0;
        if (rec) modes_log.delete();
        while (n < 60 && !seen) begin
            @(negedge clk);
            if (rec) modes_log.push_back(sel ? mode_l : mode_m);
            if (sel ? done_l : done_m) seen = 1'b1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
        if (sb.size() == 0) begin
            checkOutput("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
            ex = sb.pop_front();
            if (seen) begin
                checkOutput("gcd", 32'(sel ? gcd_l : gcd_m), 32'(ex.gcd));
                checkOutput("err", 32'(sel ? err_l : err_m), 32'(ex.err));
                if (ex.lat >= 0) checkOutput("latency", n, ex.lat);
            end
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy_m), 32'd0);
        checkOutput({tag, "_done"}, 32'(done_m), 32'd0);
        checkOutput({tag, "_gcd"},  32'(gcd_m),  32'd0);
        checkOutput({tag, "_err"},  32'(err_m),  32'd0);
        checkOutput({tag, "_mode"}, 32'(mode_m), 32'd3);
        checkOutput({tag, "_opa"},  32'(opa_m),  32'd0);
        checkOutput({tag, "_opb"},  32'(opb_m),  32'd0);
    endtask

    logic [15:0] ra_v, rb_v;
    logic        any_done;
    logic [2:0]  exp_modes[7] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3};

    initial begin
        rst = 1'b1;
        start_m = 1'b1; a_m = 16'd5; b_m = 16'd3;
        start_l = 1'b0; a_l = 16'd0; b_l = 16'd0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("rst_held");
        start_m = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkIdleOutputs("post_rst");
        checkOutput("lim_busy_rst", 32'(busy_l), 32'd0);

        $display("[TB] basic job 48,18");
        expectJob(16'd6, 1'b0, 6);
        applyStimulus(0, 16'd48, 16'd18);
        checkOutput("busy_rise", 32'(busy_m), 32'd1);
        waitDone(0, 1);
        checkOutput("mode_count", 32'(modes_log.size()), 32'd7);
        for (int i = 0; i < 7 && i < modes_log.size(); i++)
            checkOutput($sformatf("mode_seq%0d", i), 32'(modes_log[i]), 32'(exp_modes[i]));
        @(negedge clk);
        checkOutput("busy_fall", 32'(busy_m), 32'd0);
        checkOutput("gcd_hold", 32'(gcd_m), 32'd6);

        $display("[TB] degenerate and worst-case pairs");
        expectJob(16'd0, 1'b0, 3);     applyStimulus(0, 16'd0, 16'd0);         waitDone(0, 0);
        expectJob(16'd7, 1'b0, 3);     applyStimulus(0, 16'd0, 16'd7);         waitDone(0, 0);
        expectJob(16'd1, 1'b0, 4);     applyStimulus(0, 16'd65535, 16'd1);     waitDone(0, 0);
        expectJob(16'd40, 1'b0, 4);    applyStimulus(0, 16'd40, 16'd40);       waitDone(0, 0);
        expectJob(16'd1, 1'b0, 25);    applyStimulus(0, 16'd46368, 16'd28657); waitDone(0, 0);

        $display("[TB] random pairs");
        for (int i = 0; i < 6; i++) begin
            ra_v = 16'($urandom_range(0, 65535));
            rb_v = 16'($urandom_range(0, 65535));
            expectJob(stein(ra_v, rb_v), 1'b0, -1);
            applyStimulus(0, ra_v, rb_v);
            waitDone(0, 0);
        end

        $display("[TB] iteration limit");
        expectJob(16'd0, 1'b1, 5);
        applyStimulus(1, 16'd48, 16'd18);
        waitDone(1, 0);

        $display("[TB] start held high");
        @(negedge clk);
        a_m = 16'd12; b_m = 16'd8; start_m = 1'b1;
        expectJob(16'd4, 1'b0, 5);
        expectJob(16'd3, 1'b0, 5);
        @(posedge clk);
        #1;
        a_m = 16'd9; b_m = 16'd6;
        waitDone(0, 0);
        @(negedge clk);
        checkOutput("idle_gap", 32'(busy_m), 32'd0);
        @(posedge clk);
        #1;
        start_m = 1'b0;
        checkOutput("restart_busy", 32'(busy_m), 32'd1);
        waitDone(0, 0);

        $display("[TB] start pulse while busy");
        expectJob(16'd25, 1'b0, 5);
        applyStimulus(0, 16'd100, 16'd75);
        fork
            begin
                repeat (2) @(negedge clk);
                a_m = 16'd9; b_m = 16'd3; start_m = 1'b1;
                @(negedge clk);
                start_m = 1'b0;
            end
        join_none
        waitDone(0, 0);
        any_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy_m) any_done = 1'b1;
        end
        checkOutput("no_queue", 32'(any_done), 32'd0);
        checkOutput("gcd_kept", 32'(gcd_m), 32'd25);

        $display("[TB] reset during MOD");
        applyStimulus(0, 16'd48, 16'd18);
        repeat (3) @(negedge clk);
        checkOutput("mod_before_rst", 32'(mode_m), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        checkIdleOutputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_m || busy_m) any_done = 1'b1;
        end
        checkOutput("no_done_abort", 32'(any_done), 32'd0);
        expectJob(16'd7, 1'b0, 5);
        applyStimulus(0, 16'd21, 16'd14);
        waitDone(0, 0);

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
